// File: rtl/lsu_mem_stage.sv
// Load/store unit with byte-lane data memory; doubles as the MEM/WB register.
// Latency: 1 cycle, or WAIT_STATES+1 for loads; one access per cycle otherwise.
// Backpressure: stall_out is high while a load is in wait states; inputs are ignored then.
package lsu_mem_stage_pkg;
  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } control_type;
endpackage

module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = $clog2(DEPTH_WORDS) + 2,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] memory_data_in,
  input  logic [2:0]  funct3,
  input  control_type control_in,
  output logic        stall_out,
  output logic        out_valid,
  output control_type control_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] memory_data_out,
  output logic        misaligned_out
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic take_new, take_pend, park;

  logic [3:0][7:0] mem [DEPTH_WORDS];

  logic [ADDR_BITS-1:0] addr;
  logic [IDX_BITS-1:0]  widx;
  logic [1:0]           lane;
  logic                 is_rd, is_wr, size_bad, fault, accept;
  logic [3:0]           be;
  logic [3:0][7:0]      wbytes;
  logic [31:0]          rd_word, shifted, ext, load_data;

  control_type pend_ctrl;
  logic [31:0] pend_alu, pend_data;
  logic        pend_mis;

  assign addr   = alu_data_in[ADDR_BITS-1:0];
  assign widx   = addr[ADDR_BITS-1:2];
  assign lane   = addr[1:0];
  // Both strobes set is a store; the load path must not see it.
  assign is_wr  = control_in.mem_write;
  assign is_rd  = control_in.mem_read & ~control_in.mem_write;
  assign accept = (state_q == IDLE) && in_valid;

  always_comb begin
    size_bad = 1'b1;
    case (funct3)
      3'b000, 3'b100: size_bad = 1'b0;
      3'b001, 3'b101: size_bad = addr[0];
      3'b010:         size_bad = (lane != 2'b00);
      default:        size_bad = 1'b1;
    endcase
  end

  assign fault = (control_in.mem_read | control_in.mem_write) & size_bad;

  always_comb begin
    be     = 4'b0000;
    wbytes = memory_data_in;
    case (funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wbytes = {4{memory_data_in[7:0]}};
      end
      2'b01: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wbytes = {2{memory_data_in[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (!(accept && is_wr && !fault)) be = 4'b0000;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[widx][b] <= wbytes[b];
    end
  end

  assign rd_word = mem[widx];
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    ext = 32'd0;
    case (funct3)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = shifted;
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = 32'd0;
    endcase
  end

  assign load_data = (is_rd && !fault) ? ext : 32'd0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take_new  = 1'b0;
    take_pend = 1'b0;
    park      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_rd && (WAIT_STATES != 0)) begin
            state_d = BUSY;
            cnt_d   = WS_LAST;
            park    = 1'b1;
          end else begin
            take_new = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d   = IDLE;
          take_pend = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load result captured at acceptance, released when the wait states expire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_ctrl <= '0;
      pend_alu  <= 32'd0;
      pend_data <= 32'd0;
      pend_mis  <= 1'b0;
    end else if (park) begin
      pend_ctrl <= control_in;
      pend_alu  <= alu_data_in;
      pend_data <= load_data;
      pend_mis  <= fault;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      control_out     <= '0;
      alu_data_out    <= 32'd0;
      memory_data_out <= 32'd0;
      misaligned_out  <= 1'b0;
    end else begin
      out_valid <= take_new | take_pend;
      if (take_new) begin
        control_out     <= control_in;
        alu_data_out    <= alu_data_in;
        memory_data_out <= load_data;
        misaligned_out  <= fault;
      end else if (take_pend) begin
        control_out     <= pend_ctrl;
        alu_data_out    <= pend_alu;
        memory_data_out <= pend_data;
        misaligned_out  <= pend_mis;
      end
    end
  end

  assign stall_out = (state_q == BUSY);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: a zero-wait instance and a three-wait-state instance.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv0, iv3;
  logic [31:0] alu0, alu3, wd0, wd3;
  logic [2:0]  fn0, fn3;
  control_type c0, c3;
  logic        st0, st3, ov0, ov3, mis0, mis3;
  control_type co0, co3;
  logic [31:0] ao0, ao3, md0, md3;

  lsu_mem_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv0), .alu_data_in(alu0),
    .memory_data_in(wd0), .funct3(fn0), .control_in(c0), .stall_out(st0),
    .out_valid(ov0), .control_out(co0), .alu_data_out(ao0),
    .memory_data_out(md0), .misaligned_out(mis0)
  );

  lsu_mem_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv3), .alu_data_in(alu3),
    .memory_data_in(wd3), .funct3(fn3), .control_in(c3), .stall_out(st3),
    .out_valid(ov3), .control_out(co3), .alu_data_out(ao3),
    .memory_data_out(md3), .misaligned_out(mis3)
  );

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] data;
    logic        mis;
    control_type ctl;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic control_type mk_ctl(input logic rd, input logic wr);
    control_type c;
    c = '0;
    c.mem_read   = rd;
    c.mem_to_reg = rd;
    c.reg_write  = rd;
    c.mem_write  = wr;
    c.alu_src    = rd | wr;
    if (!rd && !wr) begin
      c.reg_write = 1'b1;
      c.alu_op    = 2'b10;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && ov0) begin
      if (q0.size() == 0) begin
        checks++;
        $display("FAIL ws0 spurious out_valid: alu_data_out 0x%08h", ao0);
      end else begin
        e = q0.pop_front();
        check({e.name, " data"}, md0, e.data);
        check({e.name, " alu_data_out"}, ao0, e.alu);
        check({e.name, " misaligned"}, {31'd0, mis0}, {31'd0, e.mis});
        check({e.name, " control_out"}, {24'd0, co0}, {24'd0, e.ctl});
      end
    end
    if (reset_n && ov3) begin
      if (q3.size() == 0) begin
        checks++;
        $display("FAIL ws3 spurious out_valid: alu_data_out 0x%08h", ao3);
      end else begin
        e = q3.pop_front();
        check({e.name, " data"}, md3, e.data);
        check({e.name, " alu_data_out"}, ao3, e.alu);
        check({e.name, " misaligned"}, {31'd0, mis3}, {31'd0, e.mis});
        check({e.name, " control_out"}, {24'd0, co3}, {24'd0, e.ctl});
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic issue(input int sel, input string name, input logic rd, input logic wr,
                       input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_mis, output int stalls);
    exp_t e;
    e.name = name; e.alu = addr; e.data = exp_data; e.mis = exp_mis; e.ctl = mk_ctl(rd, wr);
    if (sel == 0) begin
      iv0 = 1'b1; alu0 = addr; wd0 = wdata; fn0 = fn; c0 = e.ctl;
    end else begin
      iv3 = 1'b1; alu3 = addr; wd3 = wdata; fn3 = fn; c3 = e.ctl;
    end
    stalls = 0;
    while (((sel == 0) ? st0 : st3) && stalls < 40) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 40) begin
      checks++;
      $display("FAIL %s: never accepted, stall_out stuck", name);
    end else if (sel == 0) q0.push_back(e);
    else q3.push_back(e);
    @(negedge clk);
    if (sel == 0) begin
      iv0 = 1'b0;
      check({name, " out_valid next cycle"}, {31'd0, ov0}, 32'd1);
    end else begin
      iv3 = 1'b0;
    end
  endtask

  task automatic op(input int sel, input string name, input logic rd, input logic wr,
                    input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_data, input logic exp_mis);
    int s;
    issue(sel, name, rd, wr, fn, addr, wdata, exp_data, exp_mis, s);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q3.size()) != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", q0.size() + q3.size(), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " ws0 stall_out"}, {31'd0, st0}, 32'd0);
    check({tag, " ws0 out_valid"}, {31'd0, ov0}, 32'd0);
    check({tag, " ws0 outputs"}, ao0 | md0 | {24'd0, co0} | {31'd0, mis0}, 32'd0);
    check({tag, " ws3 stall_out"}, {31'd0, st3}, 32'd0);
    check({tag, " ws3 out_valid"}, {31'd0, ov3}, 32'd0);
    check({tag, " ws3 alu_data_out"}, ao3, 32'd0);
    check({tag, " ws3 memory_data_out"}, md3, 32'd0);
    check({tag, " ws3 control_out"}, {24'd0, co3}, 32'd0);
    check({tag, " ws3 misaligned"}, {31'd0, mis3}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    int s;
    iv0 = 0; alu0 = 0; wd0 = 0; fn0 = 0; c0 = '0;
    iv3 = 0; alu3 = 0; wd3 = 0; fn3 = 0; c3 = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Zero wait states: back-to-back traffic, one result per cycle.
    op(0, "SW 0x10",        0, 1, 3'b010, 32'h10, 32'h8899AABB, 32'h0, 1'b0);
    op(0, "LB 0x11",        1, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0);
    op(0, "LBU 0x11",       1, 0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0);
    op(0, "LH 0x12",        1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0);
    op(0, "LHU 0x12",       1, 0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0);
    op(0, "LW 0x10",        1, 0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0);
    op(0, "LB 0x13",        1, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0);
    op(0, "LBU 0x10",       1, 0, 3'b100, 32'h10, 32'h0, 32'h000000BB, 1'b0);
    op(0, "LH 0x10",        1, 0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0);
    op(0, "SB 0x13",        0, 1, 3'b000, 32'h13, 32'hDEADBE55, 32'h0, 1'b0);
    op(0, "LW after SB",    1, 0, 3'b010, 32'h10, 32'h0, 32'h5599AABB, 1'b0);
    op(0, "SH 0x10",        0, 1, 3'b001, 32'h10, 32'hCAFE1234, 32'h0, 1'b0);
    op(0, "LW after SH",    1, 0, 3'b010, 32'h10, 32'h0, 32'h55991234, 1'b0);
    op(0, "LW mis 0x12",    1, 0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    op(0, "SH mis 0x11",    0, 1, 3'b001, 32'h11, 32'h0000BEEF, 32'h0, 1'b1);
    op(0, "LW after badSH", 1, 0, 3'b010, 32'h10, 32'h0, 32'h55991234, 1'b0);
    op(0, "LHU mis 0x13",   1, 0, 3'b101, 32'h13, 32'h0, 32'h0, 1'b1);
    op(0, "load f3=011",    1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    op(0, "store f3=011",   0, 1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    op(0, "LW after bad st",1, 0, 3'b010, 32'h10, 32'h0, 32'h55991234, 1'b0);
    op(0, "SH 0x12",        0, 1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 1'b0);
    op(0, "LH 0x12 neg",    1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFABCD, 1'b0);
    op(0, "LW 0x10 upper",  1, 0, 3'b010, 32'h10, 32'h0, 32'hABCD1234, 1'b0);
    op(0, "ALU only",       0, 0, 3'b011, 32'h12345678, 32'h0, 32'h0, 1'b0);
    op(0, "RD+WR as store", 1, 1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
    op(0, "LW 0x20",        1, 0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);
    op(0, "SW wrap 0x1004", 0, 1, 3'b010, 32'h1004, 32'hA5A55A5A, 32'h0, 1'b0);
    op(0, "LW wrap 0x4",    1, 0, 3'b010, 32'h4, 32'h0, 32'hA5A55A5A, 1'b0);
    drain();
    check("idle out_valid", {31'd0, ov0}, 32'd0);
    check("idle alu_data_out hold", ao0, 32'h4);
    check("idle memory_data_out hold", md0, 32'hA5A55A5A);

    // Three wait states.
    issue(3, "ws3 SW 0x10", 0, 1, 3'b010, 32'h10, 32'h8899AABB, 32'h0, 1'b0, s);
    issue(3, "ws3 LW timing", 1, 0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, s);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("ws3 stall_out at T+%0d", k), {31'd0, st3}, 32'd1);
      check($sformatf("ws3 out_valid at T+%0d", k), {31'd0, ov3}, 32'd0);
      @(negedge clk);
    end
    check("ws3 stall_out at T+4", {31'd0, st3}, 32'd0);
    check("ws3 out_valid at T+4", {31'd0, ov3}, 32'd1);
    issue(3, "ws3 LW before SW", 1, 0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, s);
    issue(3, "ws3 SW in stall", 0, 1, 3'b010, 32'h14, 32'h01020304, 32'h0, 1'b0, s);
    check("ws3 SW held for stall cycles", s, 32'd3);
    issue(3, "ws3 LW 0x14", 1, 0, 3'b010, 32'h14, 32'h0, 32'h01020304, 1'b0, s);
    check("ws3 LW after store no stall", s, 32'd0);
    drain();

    // Reset in the middle of a load: the load must vanish without out_valid.
    issue(3, "ws3 LW abandoned", 1, 0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, s);
    check("ws3 busy before reset", {31'd0, st3}, 32'd1);
    void'(q3.pop_back());
    #2 reset_n = 1'b0;
    #1 check_cleared("mid-load reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(3, "ws3 SW after reset", 0, 1, 3'b010, 32'h10, 32'h8899AABB, 32'h0, 1'b0, s);
    issue(3, "ws3 LW after reset", 1, 0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, s);
    drain();
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Parametrised successor to the pipeline memory stage: a load/store unit with internal byte-lane data memory. Supports RV32I byte/halfword/word accesses with sign/zero extension, misalignment detection and configurable load wait-states with a stall handshake. All results are registered, so the block also acts as the MEM/WB pipeline register.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in data memory (power of 2)
ADDR_BITS, $clog2(DEPTH_WORDS)+2, byte-address bits used; upper address bits ignored (wrap)
WAIT_STATES, 0, extra cycles a load occupies (0..15)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction present this cycle
alu_data_in  in  32  effective address / ALU result
memory_data_in  in  32  store data (rs2)
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
control_in  in  control_type  pipeline control; uses mem_read, mem_write
stall_out  out  1  upstream must hold its inputs
out_valid  out  1  registered result valid (one-cycle pulse)
control_out  out  control_type  registered control_in
alu_data_out  out  32  registered alu_data_in
memory_data_out  out  32  extended load data; 0 for non-loads
misaligned_out  out  1  registered misalignment/illegal-size flag

Behaviour:
- Reset: async; state=IDLE, wait counter=0; all outputs 0 (control_out all-zero). Memory contents not cleared. Reset mid-load abandons the load with no out_valid.
- FSM IDLE/BUSY. stall_out = (state==BUSY), purely registered.
- Accept: in IDLE when in_valid=1. No acceptance in BUSY; inputs are ignored there.
- Address: byte addr = alu_data_in[ADDR_BITS-1:0], word index = addr[ADDR_BITS-1:2], lane = addr[1:0].
- Fault: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 in {011,110,111} during a read or write gives fault=1. A fault suppresses the memory write, forces load data to 0 and sets misaligned_out with the result.
- Store (mem_write=1, no fault): written on the acceptance edge via byte enables. SB uses lane; SH uses lanes {addr[1],0} and +1. Data is taken from the low bits of memory_data_in and replicated to lanes. A store never stalls.
- Load (mem_read=1): synchronous read at acceptance. The selected byte/half is shifted to bit 0 and then sign-extended (B, H) or zero-extended (BU, HU, W as-is).
- Latency: non-load or WAIT_STATES=0 gives out_valid at T+1 and IDLE persists, so throughput is 1 per cycle. A load with WAIT_STATES=N>0 goes to BUSY for cycles T+1..T+N with stall_out=1. It returns to IDLE and out_valid=1 at T+N+1, and a new accept is possible in that same cycle.
- mem_read and mem_write both 1: treated as a store, and memory_data_out is 0.
- in_valid=0 in IDLE: out_valid=0 next cycle. Other outputs hold their last values.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- control_out, alu_data_out and misaligned_out update only on edges where out_valid goes 1.

Test Plan:
- Reset mid-load: assert reset_n low during BUSY -> stall_out=0, out_valid=0 and all outputs 0 immediately; the same SW/LW sequence works after release.
- SW 0x8899AABB to addr 0x10, then LB/LBU/LH/LHU/LW at 0x10..0x13 (WAIT_STATES=0), back-to-back -> out_valid every cycle. Expected data: LB@0x11 gives 0xFFFFFFAA, LBU@0x11 gives 0x000000AA, LH@0x12 gives 0xFFFF8899, LHU@0x12 gives 0x00008899, LW@0x10 gives 0x8899AABB.
- SB 0x55 to 0x13 over 0x8899AABB, then LW 0x10 -> 0x5599AABB. SH 0x1234 to 0x10, then LW -> 0x55991234.
- Misaligned: LW at 0x12 -> misaligned_out=1 and data 0. SH at 0x11 -> misaligned_out=1 and memory is unchanged (verified by LW). funct3=011 is also flagged.
- WAIT_STATES=3: LW at T -> stall_out=1 at T+1..T+3, out_valid=1 with data at T+4. A following SW presented during the stall is written only once, accepted at T+4.
- Wrap: with DEPTH_WORDS=1024, SW to 0x00001004, then LW at 0x4 -> same data.
